// File: rtl/cr_sched_pkg.sv
// Shared types and constants for the round-robin credit scheduler.
package cr_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} cr_state_t;

    localparam int CR_TRANS = 15;

    // A single requester still needs a 1-bit index.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cr_sched_rr_arb.sv
// Combinational round-robin picker: first eligible requester at or after ptr, wrapping.
module rr_arb
    import cr_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [IW-1:0]    ptr,
    output logic             any,
    output logic [N_REQ-1:0] win_oh,
    output logic [IW-1:0]    win_idx
);
    always_comb begin
        int idx;
        idx     = 0;
        any     = |elig;
        win_idx = '0;
        win_oh  = '0;
        // Walk offsets from far to near so the nearest eligible index wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (elig[idx]) win_idx = IW'(idx);
        end
        if (any) win_oh[win_idx] = 1'b1;
    end
endmodule

// File: rtl/cr_sched.sv
// Round-robin credit scheduler: grants one requester at a time when credits and
// its outstanding limit allow, then waits GAP cycles for the credit count to settle.
module cr_sched
    import cr_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int MAX_OUTST = 3,
    parameter  int CR_MIN    = CR_TRANS,
    parameter  int GAP       = 1,
    localparam int IW        = id_w(N_REQ)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    input  logic             transaction_enable,
    input  logic [7:0]       credit_cnt,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    grant_id,
    output logic             transaction_start,
    output logic             busy,
    output logic             err_done
);
    localparam logic signed [7:0] CR_MIN_S = 8'(CR_MIN);

    cr_state_t               state;
    logic [IW-1:0]           ptr;
    logic [IW-1:0]           w;
    logic [1:0]              cnt;
    logic [N_REQ-1:0][2:0]   outst;
    logic [N_REQ-1:0]        elig;
    logic [N_REQ-1:0]        win_oh;
    logic [IW-1:0]           win_idx;
    logic                    any;
    logic                    cr_ok;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++)
            elig[i] = req[i] && (outst[i] < 3'(MAX_OUTST));
    end

    assign cr_ok = transaction_enable && ($signed(credit_cnt) >= CR_MIN_S);

    rr_arb #(.N_REQ(N_REQ)) u_arb (
        .elig    (elig),
        .ptr     (ptr),
        .any     (any),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= IDLE;
            ptr               <= '0;
            w                 <= '0;
            cnt               <= '0;
            gnt               <= '0;
            transaction_start <= 1'b0;
            grant_id          <= '0;
            busy              <= 1'b0;
        end else begin
            gnt               <= '0;
            transaction_start <= 1'b0;
            case (state)
                IDLE: if (cr_ok && any) begin
                    // Winner is latched here; a later req drop cannot cancel the grant.
                    w                 <= win_idx;
                    gnt               <= win_oh;
                    transaction_start <= 1'b1;
                    grant_id          <= win_idx;
                    busy              <= 1'b1;
                    ptr               <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                    state             <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= 2'(GAP - 1);
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == 2'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The grant pulse is visible while in ISSUE, so that cycle carries the increment.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            outst    <= '0;
            err_done <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if ((state == ISSUE) && (w == IW'(i)) && !done[i]) begin
                    outst[i] <= outst[i] + 3'd1;
                end else if (done[i] && !((state == ISSUE) && (w == IW'(i)))) begin
                    if (outst[i] == 3'd0) err_done <= 1'b1;
                    else                  outst[i] <= outst[i] - 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cr_sched.sv
// Directed and random checks of cr_sched against a grant-level reference model.
module tb_cr_sched;
    localparam int N     = 4;
    localparam int MO    = 3;
    localparam int GAP   = 1;
    localparam int CRMIN = 15;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic         transaction_enable;
    logic [7:0]   credit_cnt;
    logic [N-1:0] gnt;
    logic [1:0]   grant_id;
    logic         transaction_start;
    logic         busy;
    logic         err_done;

    cr_sched #(.N_REQ(N), .MAX_OUTST(MO), .CR_MIN(CRMIN), .GAP(GAP)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .req                (req),
        .done               (done),
        .transaction_enable (transaction_enable),
        .credit_cnt         (credit_cnt),
        .gnt                (gnt),
        .grant_id           (grant_id),
        .transaction_start  (transaction_start),
        .busy               (busy),
        .err_done           (err_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    // Model: outstanding counts, rotating priority, earliest cycle a new grant may be decided.
    int           m_outst [N];
    int           m_ptr  = 0;
    int           m_free = 0;
    logic [N-1:0] m_gnt  = '0;
    int           m_gid  = 0;
    logic         m_busy = 1'b0;
    logic         m_err  = 1'b0;

    int g_id  [$];
    int g_cyc [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rn, input logic [N-1:0] rq, input logic [N-1:0] dn,
                       input logic en, input logic [7:0] cr);
        logic [N-1:0] cur;
        logic [N-1:0] elig;
        logic         ok;
        int           w;
        reset_n = rn; req = rq; done = dn; transaction_enable = en; credit_cnt = cr;
        cur = m_gnt;
        if (!rn) begin
            foreach (m_outst[i]) m_outst[i] = 0;
            m_ptr = 0; m_free = cyc_n + 1; m_gnt = '0; m_gid = 0; m_busy = 1'b0; m_err = 1'b0;
        end else begin
            ok = en && (int'($signed(cr)) >= CRMIN);
            for (int i = 0; i < N; i++) elig[i] = rq[i] && (m_outst[i] < MO);
            m_gnt = '0;
            if (cyc_n >= m_free && ok && elig != '0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                m_gnt[w] = 1'b1;
                m_gid    = w;
                m_ptr    = (w + 1) % N;
                m_free   = cyc_n + 2 + GAP;
            end
            for (int i = 0; i < N; i++) begin
                if (dn[i] && !cur[i]) begin
                    if (m_outst[i] == 0) m_err = 1'b1;
                    else                 m_outst[i]--;
                end else if (cur[i] && !dn[i]) begin
                    m_outst[i]++;
                end
            end
            m_busy = (cyc_n + 1 < m_free);
        end
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        check("gnt", 32'(gnt), 32'(m_gnt));
        check("transaction_start", 32'(transaction_start), 32'(|m_gnt));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        check("busy", 32'(busy), 32'(m_busy));
        check("err_done", 32'(err_done), 32'(m_err));
        if (gnt != '0) begin
            g_id.push_back(int'(grant_id));
            g_cyc.push_back(cyc_n);
        end
    endtask

    function automatic int q_at(input int q [$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    initial begin
        int c0;
        reset_n = 1'b0; req = '0; done = '0; transaction_enable = 1'b0; credit_cnt = '0;
        @(negedge clk);

        // Single request: req at cycle 5, grant at cycle 6, busy 6..7.
        cyc(0, 4'b0000, 4'b0000, 1, 8'd32);
        cyc(0, 4'b0000, 4'b0000, 1, 8'd32);
        repeat (3) cyc(1, 4'b0000, 4'b0000, 1, 8'd32);
        cyc(1, 4'b0001, 4'b0000, 1, 8'd32);
        cyc(1, 4'b0001, 4'b0000, 1, 8'd32);
        repeat (4) cyc(1, 4'b0000, 4'b0000, 1, 8'd32);
        check("single_cycle", 32'(q_at(g_cyc, 0)), 32'd6);
        check("single_count", 32'(g_id.size()), 32'd1);

        // Round robin with all requesting.
        g_id.delete(); g_cyc.delete();
        cyc(0, 4'b0000, 4'b0000, 1, 8'd100);
        repeat (16) cyc(1, 4'b1111, 4'b0000, 1, 8'd100);
        for (int k = 0; k < 5; k++) check($sformatf("rr_id%0d", k), 32'(q_at(g_id, k)), 32'(k % 4));
        for (int k = 1; k < 5; k++)
            check($sformatf("rr_gap%0d", k), 32'(q_at(g_cyc, k) - q_at(g_cyc, k - 1)), 32'd3);

        // Credit threshold and negative credit.
        g_id.delete(); g_cyc.delete();
        cyc(0, 4'b0000, 4'b0000, 1, 8'd14);
        repeat (6) cyc(1, 4'b0001, 4'b0000, 1, 8'd14);
        check("low_credit_none", 32'(g_id.size()), 32'd0);
        c0 = cyc_n;
        cyc(1, 4'b0001, 4'b0000, 1, 8'd15);
        check("credit15_cycle", 32'(q_at(g_cyc, 0)), 32'(c0 + 1));
        repeat (8) cyc(1, 4'b0001, 4'b0000, 1, 8'hF0);
        check("neg_credit_none", 32'(g_id.size()), 32'd1);

        // Outstanding limit, release by done, grant coinciding with done.
        g_id.delete(); g_cyc.delete();
        cyc(0, 4'b0000, 4'b0000, 1, 8'd100);
        repeat (20) cyc(1, 4'b0001, 4'b0000, 1, 8'd100);
        check("outst_stall", 32'(g_id.size()), 32'd3);
        c0 = cyc_n;
        cyc(1, 4'b0001, 4'b0001, 1, 8'd100);
        cyc(1, 4'b0001, 4'b0000, 1, 8'd100);
        check("done_regrant", 32'(q_at(g_cyc, 3)), 32'(c0 + 2));
        cyc(1, 4'b0001, 4'b0001, 1, 8'd100);
        repeat (12) cyc(1, 4'b0001, 4'b0000, 1, 8'd100);
        check("outst_total", 32'(g_id.size()), 32'd5);

        // Spurious done, then reset during SETTLE.
        g_id.delete(); g_cyc.delete();
        cyc(0, 4'b0000, 4'b0000, 1, 8'd100);
        cyc(1, 4'b0000, 4'b0100, 1, 8'd100);
        check("err_rise", 32'(err_done), 32'd1);
        repeat (5) cyc(1, 4'b0000, 4'b0000, 1, 8'd100);
        check("err_hold", 32'(err_done), 32'd1);
        for (int k = 0; k < 10 && g_id.size() == 0; k++) cyc(1, 4'b0100, 4'b0000, 1, 8'd100);
        check("err_grant_id", 32'(q_at(g_id, 0)), 32'd2);
        cyc(1, 4'b0000, 4'b0000, 1, 8'd100);
        c0 = cyc_n;
        cyc(0, 4'b0000, 4'b0000, 1, 8'd100);
        check("rst_outputs", 32'({gnt, grant_id, transaction_start, busy, err_done}), 32'd0);
        cyc(1, 4'b0100, 4'b0000, 1, 8'd100);
        check("rst_regrant_cycle", 32'(q_at(g_cyc, 1)), 32'(c0 + 2));
        check("rst_regrant_id", 32'(q_at(g_id, 1)), 32'd2);
        repeat (3) cyc(1, 4'b0000, 4'b0000, 1, 8'd100);

        // Random traffic against the model.
        repeat (400) begin
            logic [N-1:0] dn;
            for (int i = 0; i < N; i++) dn[i] = ($urandom % 8) == 0;
            cyc(($urandom % 60) != 0, 4'($urandom), dn, ($urandom % 8) != 0,
                (($urandom % 4) == 0) ? 8'($urandom) : 8'($urandom_range(10, 40)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cr_sched.md
# cr_sched

Round-robin credit scheduler that sits in front of the credit counter. It shares the output-FIFO credit pool between `N_REQ` transaction requesters. A requester is granted only when enough credits exist and its own outstanding-transaction limit is not exceeded. Each grant produces the single-cycle `transaction_start` pulse that the credit counter consumes, then waits for the counter to settle before granting again.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `MAX_OUTST`, default 3: maximum granted-but-not-done transactions per requester, 1..7.
- `CR_MIN`, default 15: minimum signed `credit_cnt` required to grant; one transaction costs 15 credits.
- `GAP`, default 1: settle cycles after each grant, 1..3.

Ports:
- `clk`, in, 1: clock. One clock domain.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `req`, in, N_REQ: per-requester request level. Held until `gnt`; dropping it earlier withdraws the request.
- `done`, in, N_REQ: one-cycle pulse per completed transaction of requester i.
- `transaction_enable`, in, 1: from credit counter; 1 means credit is available.
- `credit_cnt`, in, 8: credit count from the credit counter, two's complement.
- `gnt`, out, N_REQ: one-hot, one-cycle grant pulse.
- `grant_id`, out, clog2(N_REQ): index of the last grant; holds between grants.
- `transaction_start`, out, 1: one-cycle pulse, coincident with `gnt`.
- `busy`, out, 1: 1 while the FSM is in ISSUE or SETTLE.
- `err_done`, out, 1: sticky flag set by a `done` pulse when that requester's outstanding count is 0.

## Operation

- Eligibility: `elig[i] = req[i] & (outst[i] < MAX_OUTST)`.
- Credit check: `cr_ok = transaction_enable & ($signed(credit_cnt) >= CR_MIN)`.

FSM states are IDLE, ISSUE and SETTLE.
- **IDLE:** if `cr_ok` and any `elig`, register the round-robin winner and go to ISSUE. Otherwise stay in IDLE.
- **ISSUE:** assert `gnt[w]`, `transaction_start` and `grant_id=w` for exactly one cycle, then go to SETTLE.
- **SETTLE:** count `GAP` cycles with no grants, then return to IDLE.

Round robin:
- Priority starts at pointer `ptr` and wraps modulo N_REQ.
- After each grant, `ptr = w+1`, wrapping to 0 at N_REQ.

Outstanding counters `outst[i]`, 3 bits:
- +1 on grant to i; −1 on `done[i]`.
- Grant and `done[i]` in the same cycle: net 0.
- `done[i]` with `outst[i]==0`: counter stays 0 and `err_done` is set.
- No wrap is possible: grants are blocked at `MAX_OUTST`.

Other boundary rules:
- Credits are re-evaluated only in IDLE. Changes to `credit_cnt` during ISSUE or SETTLE are ignored.
- The winner is latched at the IDLE→ISSUE transition. If `req[w]` drops during ISSUE, the grant still fires; requesters must not withdraw after being selected.
- `done` is accepted in every state.
- `reset_n=0` at any clock edge, including mid-SETTLE, forces on the next edge:
  - state IDLE, `ptr=0`, all `outst=0`;
  - `gnt=0`, `transaction_start=0`, `grant_id=0`, `busy=0`, `err_done=0`.

## Timing

- All outputs are registered.
- Request latency: `req` is seen with `cr_ok` in IDLE at cycle t; `gnt` and `transaction_start` are high at t+1.
- SETTLE occupies t+2 .. t+1+GAP. IDLE is re-entered at t+2+GAP.
- Earliest next grant is at t+3+GAP, i.e. one grant every 3 cycles at GAP=1.
- GAP=1 covers the credit counter's one-cycle update: `credit_cnt` reflects the start pulse issued at t+1 by cycle t+2.
- `err_done` rises on the clock edge that samples the offending `done` and stays high until reset.

## Structure

- Package `cr_pkg`:
  - `typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} cr_state_t`;
  - `localparam CR_TRANS = 15`;
  - a `clog2`-based width helper for `grant_id`.
- Sub-module `rr_arb`: combinational round-robin picker. Inputs are `elig` and `ptr`; outputs are `any` and the one-hot/index winner.
- FSM, outstanding counters and `ptr` register stay in `cr_sched`.

## Test plan

- **Single request:** reset, `credit_cnt=32`, `transaction_enable=1`, `req=0001` at cycle 5 → `gnt=0001` and `transaction_start=1` at cycle 6 only, `busy` high in cycles 6–7, `outst[0]=1`.
- **Round robin:** `req=1111` held, credits 100 → grants 0,1,2,3,0 exactly 3 cycles apart; `grant_id` follows.
- **Low credit:** `credit_cnt=14` → no grant. Raise to 15 in IDLE → grant on the next cycle. `credit_cnt=8'hF0` (negative) → no grant.
- **Outstanding limit:** `req=0001`, credits 100, no `done` → exactly 3 grants then stall. `done[0]` pulse → 4th grant 2 cycles later. Simultaneous grant and `done[0]` leaves `outst[0]` unchanged.
- **Spurious done:** `done[2]` with `outst[2]=0` → `err_done=1` next cycle, held until reset. `outst[2]` stays 0.
- **Reset mid-operation:** `reset_n=0` during SETTLE → next edge all outputs 0, `outst=0`. After release, `req=0100` → grant to requester 2 two cycles later.
